wb_ram_slave: RTL
=================

Name: wb_ram_slave

Overview:
- Wishbone classic single-port RAM responder: the slave end of the ibus/dbus Wishbone master ports that openmips drives.
- Accepts single read/write cycles, applies byte selects, and returns ack after a configurable number of wait states.
- Flags out-of-window addresses with err.
- Instantiated in the SOPC once per bus: instruction memory (writes unused) and data memory.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- DEPTH_LOG2, 12: log2 of memory depth in 32-bit words (default 16 KiB).
- WAIT_STATES, 1: extra cycles between request acceptance and ack; legal range 0..15.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous, active-low reset
- i_wb_addr  input  32  byte address (`N_INST_ADDR width)
- i_wb_data  input  32  write data (`N_REG width)
- i_wb_we  input  1  1=write, 0=read
- i_wb_sel  input  4  byte lane enables; sel[i] maps to data[8i+7:8i]
- i_wb_stb  input  1  strobe
- i_wb_cyc  input  1  cycle valid
- o_wb_data  output  32  read data, valid only while o_wb_ack=1
- o_wb_ack  output  1  normal termination, one-cycle pulse
- o_wb_err  output  1  error termination, one-cycle pulse

Behaviour:
- Interface: one clock i_clk; reset is synchronous and active-low on i_rst_n.
- Reset values (i_rst_n=0 sampled at a rising edge):
  - o_wb_ack=0, o_wb_err=0, o_wb_data=0, FSM=IDLE, wait counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On i_wb_cyc&i_wb_stb, latch addr/data/we/sel.
  - If WAIT_STATES=0, go to RESP.
  - Otherwise go to WAIT with counter=WAIT_STATES-1.
- WAIT:
  - If i_wb_cyc=0 or i_wb_stb=0, abort: go to IDLE with no write, no ack, no err.
  - Else if counter==0, go to RESP; else decrement the counter.
- RESP:
  - Exactly one cycle with o_wb_ack or o_wb_err high, then IDLE unconditionally.
  - A request present during RESP is not accepted.
- Latency:
  - Ack/err goes high on the edge WAIT_STATES+1 cycles after the request edge; with WAIT_STATES=1 that is the second edge.
  - Back-to-back transfers have one IDLE cycle between ack and the next acceptance.
- Address check: offset = latched_addr - BASE_ADDR.
  - In range if offset < 4*2^DEPTH_LOG2 (unsigned; addresses below BASE_ADDR wrap to large values and are out of range).
  - Word index = offset[DEPTH_LOG2+1:2]; offset[1:0] is ignored.
- Write:
  - Committed on the same edge that enters RESP, only if in range.
  - Only lanes with sel=1 are updated; sel=4'b0000 is a legal no-op write that still acks.
- Read:
  - The array is read on the edge entering RESP.
  - o_wb_data holds the full word regardless of sel while ack=1, and is 0 in every other cycle, including err.
- Out of range: o_wb_err=1 instead of ack, no write, o_wb_data=0.
- o_wb_ack and o_wb_err are never high together and are never asserted without a prior accepted request.
- Reset mid-transfer: FSM returns to IDLE and any pending write is dropped. The master must restart the cycle.
- Writes to the same word in consecutive transfers read back the latest value (no bypass needed because of the IDLE gap).

Decomposition:
- Shared package wb_pkg:
  - wb_state_e enum {IDLE, WAIT, RESP}
  - WB_SEL_W=4
  - WB_DATA_W/WB_ADDR_W, tied to `N_REG/`N_INST_ADDR from defines.svh
- One sub-module wb_ram_array: synchronous byte-enable single-port array (i_clk, i_we, i_be[3:0], i_addr[DEPTH_LOG2-1:0], i_data, o_data registered).
- The FSM, counter, address check and response muxing stay in wb_ram_slave.

Test Plan:
- Reset/idle: reset with stb=cyc=0 for 5 cycles -> ack=err=0 and o_wb_data=0 throughout.
- Full-word write then read, WAIT_STATES=1:
  - Write 32'hDEADBEEF to 0x10 with sel=4'hF -> ack on the 2nd edge after request, for exactly 1 cycle.
  - Read 0x10 -> ack with o_wb_data=32'hDEADBEEF.
- Byte lanes: write 32'h11223344 with sel=4'b0101 over prior 32'hDEADBEEF at 0x10 -> read returns 32'hDE22BE44.
- Out of range: DEPTH_LOG2=12, BASE_ADDR=0, read and write at 0x4000 -> err pulse, no ack, data=0; address 0x0000 unchanged.
- Abort: WAIT_STATES=3, drop stb one cycle after a write request to 0x20 of 32'hCAFEF00D -> no ack/err; subsequent read of 0x20 returns the prior value.
- Zero wait and back-to-back: WAIT_STATES=0 with a held request stream -> ack one edge after acceptance, then one IDLE cycle before the next ack. Reset asserted during WAIT drops the write.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone types, widths and the address window check used by the RAM responder.
package wb_pkg;

  // Bus widths follow the openmips instruction-address and register widths.
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // True when a byte offset lands inside a window of 2^depth_log2 words.
  // The compare is one bit wider than the bus so a full 4 GiB window cannot overflow.
  function automatic logic in_window(input logic [WB_ADDR_W-1:0] offset,
                                     input int unsigned          depth_log2);
    logic [WB_ADDR_W:0] limit;
    limit = {{WB_ADDR_W{1'b0}}, 1'b1} << (depth_log2 + 2);
    return ({1'b0, offset} < limit);
  endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Single-port word array with per-byte write enables and a registered read port.
module wb_ram_array
  import wb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [WB_SEL_W-1:0]   i_be,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WB_DATA_W-1:0]  i_data,
  output logic [WB_DATA_W-1:0]  o_data
);

  logic [WB_DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [WB_DATA_W-1:0] rd_data_q;

  // Byte-lane writes and read-first registered read of the addressed word.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < WB_SEL_W; b++) begin
      if (i_we && i_be[b]) begin
        mem[i_addr][8*b +: 8] <= i_data[8*b +: 8];
      end
    end
    rd_data_q <= mem[i_addr];
  end

  assign o_data = rd_data_q;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM responder with programmable wait states and window error.
//
//   state | meaning
//   IDLE  | waiting for cyc&stb; accepts and latches the request
//   WAIT  | counting down wait states; dropping cyc/stb aborts silently
//   RESP  | single cycle with ack (in window) or err (out of window)
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                   DEPTH_LOG2  = 12,
  parameter int                   WAIT_STATES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WB_ADDR_W-1:0] i_wb_addr,
  input  logic [WB_DATA_W-1:0] i_wb_data,
  input  logic                 i_wb_we,
  input  logic [WB_SEL_W-1:0]  i_wb_sel,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_cyc,
  output logic [WB_DATA_W-1:0] o_wb_data,
  output logic                 o_wb_ack,
  output logic                 o_wb_err
);

  // Countdown preload: the accept edge already consumes one of the wait cycles.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WB_ADDR_W-1:0] addr_q, addr_d;
  logic [WB_DATA_W-1:0] data_q, data_d;
  logic                 we_q, we_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic                 req;
  logic                 go_resp;
  logic [WB_ADDR_W-1:0] eff_addr;
  logic [WB_DATA_W-1:0] eff_data;
  logic                 eff_we;
  logic [WB_SEL_W-1:0]  eff_sel;
  logic [WB_ADDR_W-1:0] offset;
  logic                 in_range;
  logic                 mem_we;
  logic [WB_DATA_W-1:0] mem_rdata;

  // Next-state, wait countdown and request latching. With zero wait states the
  // array is addressed straight from the bus, so eff_* selects the live request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    sel_d    = sel_q;
    go_resp  = 1'b0;
    req      = i_wb_cyc & i_wb_stb;
    eff_addr = addr_q;
    eff_data = data_q;
    eff_we   = we_q;
    eff_sel  = sel_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d   = i_wb_addr;
          data_d   = i_wb_data;
          we_d     = i_wb_we;
          sel_d    = i_wb_sel;
          eff_addr = i_wb_addr;
          eff_data = i_wb_data;
          eff_we   = i_wb_we;
          eff_sel  = i_wb_sel;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window check and termination select; writes are held off while reset is low.
  always_comb begin
    offset   = eff_addr - BASE_ADDR;
    in_range = in_window(offset, DEPTH_LOG2);
    ack_d    = go_resp & in_range;
    err_d    = go_resp & ~in_range;
    mem_we   = ack_d & eff_we & i_rst_n;
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  wb_ram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .i_clk (i_clk),
    .i_we  (mem_we),
    .i_be  (eff_sel),
    .i_addr(offset[DEPTH_LOG2+1:2]),
    .i_data(eff_data),
    .o_data(mem_rdata)
  );

  assign o_wb_ack  = ack_q;
  assign o_wb_err  = err_q;
  assign o_wb_data = ack_q ? mem_rdata : '0;

endmodule
